// File: rtl/fi_fractal_scan.sv
// fi_fractal_scan: raster-scan controller for the Julia-set generator with valid/ready pixel output
module fi_fractal_scan #(
  parameter int WS      = 16,
  parameter int MAXITER = 23,
  parameter int CW      = 5,
  parameter int HRES    = 1280,
  parameter int VRES    = 720,
  parameter int SETTLE  = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iStart,
  input  logic [2*WS-1:0]   iC,
  input  logic [WS-1:0]     iThres,
  output logic [WS-1:0]     oX,
  output logic [WS-1:0]     oY,
  output logic [2*WS-1:0]   oC,
  output logic [WS-1:0]     oThres,
  input  logic [MAXITER-1:0] iIterCnt,
  output logic              oPixValid,
  input  logic              iPixReady,
  output logic [CW-1:0]     oPixCnt,
  output logic [23:0]       oPixRGB,
  output logic              oSOF,
  output logic              oEOL,
  output logic              oBusy,
  output logic              oDone
);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_OUT, S_DONE} state_t;
  state_t          r_state;
  logic [SW-1:0]   r_wait;
  logic [CW-1:0]   w_cnt;
  logic [7:0]      w_r;
  logic [23:0]     w_rgb;
  logic            w_last_x;
  logic            w_last_y;
  // thermometer decode: index of the highest set bit, 0 when no bit is set
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < MAXITER; i++)
      if (iIterCnt[i]) w_cnt = CW'(i);
  end
  assign w_r      = 8'(w_cnt) << (8 - CW);
  assign w_rgb    = {w_r, ~w_r, (w_cnt == CW'(MAXITER - 1)) ? 8'h00 : 8'h80};
  assign w_last_x = (oX == WS'(HRES - 1));
  assign w_last_y = (oY == WS'(VRES - 1));
  // frame sequencer: load, settle/capture/output per pixel, then done pulse
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      oX        <= '0;
      oY        <= '0;
      oC        <= '0;
      oThres    <= '0;
      oPixValid <= 1'b0;
      oPixCnt   <= '0;
      oPixRGB   <= '0;
      oSOF      <= 1'b0;
      oEOL      <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (iStart) r_state <= S_LOAD;
        S_LOAD: begin
          oC      <= iC;
          oThres  <= iThres;
          oX      <= '0;
          oY      <= '0;
          oBusy   <= 1'b1;
          r_wait  <= SW'(SETTLE - 1);
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_wait == '0) r_state <= S_CAPTURE;
          else r_wait <= r_wait - 1'b1;
        end
        S_CAPTURE: begin
          oPixCnt   <= w_cnt;
          oPixRGB   <= w_rgb;
          oPixValid <= 1'b1;
          oSOF      <= (oX == '0) && (oY == '0);
          oEOL      <= w_last_x;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (iPixReady) begin
            oPixValid <= 1'b0;
            oSOF      <= 1'b0;
            oEOL      <= 1'b0;
            if (w_last_x && w_last_y) begin
              oDone   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              oX      <= w_last_x ? '0 : oX + WS'(1);
              if (w_last_x) oY <= oY + WS'(1);
              r_wait  <= SW'(SETTLE - 1);
              r_state <= S_SETTLE;
            end
          end
        end
        S_DONE: begin
          oDone   <= 1'b0;
          oBusy   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
